// File: rtl/sys_array_pkg.sv
// Shared types and helpers for the systolic array sequencing controller.
// Holds the run-state enum, default size maxima with the index widths
// derived from them, and the feed-phase length function.
package sys_array_pkg;

  localparam int ARRAY_MAX_W_DEF   = 5;
  localparam int ARRAY_MAX_L_DEF   = 5;
  localparam int ARRAY_MAX_A_L_DEF = 5;
  localparam int CNT_WIDTH_DEF     = 16;

  // Widths of the config fields and row indices at the default maxima
  localparam int CFG_W_W   = $clog2(ARRAY_MAX_W_DEF + 1);
  localparam int CFG_L_W   = $clog2(ARRAY_MAX_L_DEF + 1);
  localparam int CFG_A_W   = $clog2(ARRAY_MAX_A_L_DEF + 1);
  localparam int ROW_IDX_W = $clog2(ARRAY_MAX_W_DEF);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    LOAD_W = 3'd2,
    FEED   = 3'd3,
    OUTPUT = 3'd4,
    DONE   = 3'd5
  } state_t;

  // Skewed feed length: last data column reaches the far corner PE
  function automatic int unsigned feed_len(input int unsigned w,
                                           input int unsigned l,
                                           input int unsigned a);
    return a + w + l - 2;
  endfunction

endpackage

// File: rtl/sys_array_phase_cnt.sv
// Phase counter shared by all timed phases of the controller.
// load: set remaining length to load_val and index to 0 (wins over en).
// en:   count remaining down and index up by one.
// last: high while the current cycle is the final one of the phase.
// idx:  index of the current cycle within the phase.
module sys_array_phase_cnt #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] load_val,
  output logic             last,
  output logic [WIDTH-1:0] idx
);

  logic [WIDTH-1:0] rem;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rem <= '0;
      idx <= '0;
    end else if (load) begin
      rem <= load_val;
      idx <= '0;
    end else if (en) begin
      rem <= rem - 1'b1;
      idx <= idx + 1'b1;
    end
  end

  assign last = (rem == WIDTH'(1));

endmodule

// File: rtl/sys_array_ctrl.sv
// Sequencing controller for the weight-stationary systolic array.
// A 0->1 edge of start_comp (in IDLE or DONE) with a legal config runs
// CLEAR -> LOAD_W (W) -> FEED (A+W+L-2) -> OUTPUT (W) -> DONE.
// Ports: clk/reset_n (sync, active low); start_comp level request;
// cfg_w/cfg_l/cfg_a_l sizes latched at start; busy/ready/cfg_err status;
// pe_clear, w_load_en+w_row_idx, a_feed_en+feed_step, out_valid+out_row_idx
// strobes to the datapath; cnt saturating cycles-since-start.
module sys_array_ctrl
  import sys_array_pkg::*;
#(
  parameter int ARRAY_MAX_W   = ARRAY_MAX_W_DEF,
  parameter int ARRAY_MAX_L   = ARRAY_MAX_L_DEF,
  parameter int ARRAY_MAX_A_L = ARRAY_MAX_A_L_DEF,
  parameter int CNT_WIDTH     = CNT_WIDTH_DEF
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               start_comp,
  input  logic [$clog2(ARRAY_MAX_W+1)-1:0]   cfg_w,
  input  logic [$clog2(ARRAY_MAX_L+1)-1:0]   cfg_l,
  input  logic [$clog2(ARRAY_MAX_A_L+1)-1:0] cfg_a_l,
  output logic                               busy,
  output logic                               ready,
  output logic                               cfg_err,
  output logic                               pe_clear,
  output logic                               w_load_en,
  output logic [$clog2(ARRAY_MAX_W)-1:0]     w_row_idx,
  output logic                               a_feed_en,
  output logic [CNT_WIDTH-1:0]               feed_step,
  output logic                               out_valid,
  output logic [$clog2(ARRAY_MAX_W)-1:0]     out_row_idx,
  output logic [CNT_WIDTH-1:0]               cnt
);

  localparam int WW = $clog2(ARRAY_MAX_W + 1);
  localparam int LW = $clog2(ARRAY_MAX_L + 1);
  localparam int AW = $clog2(ARRAY_MAX_A_L + 1);
  localparam int IW = $clog2(ARRAY_MAX_W);

  localparam logic [WW-1:0] MAX_W_C = WW'(ARRAY_MAX_W);
  localparam logic [LW-1:0] MAX_L_C = LW'(ARRAY_MAX_L);
  localparam logic [AW-1:0] MAX_A_C = AW'(ARRAY_MAX_A_L);

  state_t         state;
  logic           start_d;
  logic [WW-1:0]  w_q;
  logic [LW-1:0]  l_q;
  logic [AW-1:0]  a_q;

  logic                 start_edge, cfg_ok;
  logic                 ph_ld, ph_en, ph_last;
  logic [CNT_WIDTH-1:0] ph_val, ph_idx, f_len, w_len;

  assign start_edge = start_comp & ~start_d;
  assign cfg_ok = (cfg_w != '0) && (cfg_w <= MAX_W_C) &&
                  (cfg_l != '0) && (cfg_l <= MAX_L_C) &&
                  (cfg_a_l != '0) && (cfg_a_l <= MAX_A_C);
  assign busy  = (state != IDLE) && (state != DONE);
  assign f_len = CNT_WIDTH'(feed_len(32'(w_q), 32'(l_q), 32'(a_q)));
  assign w_len = CNT_WIDTH'(w_q);

  // Counter is loaded on entry to each timed phase (from CLEAR and on the
  // last cycle of the previous phase) and stepped inside it.
  always_comb begin
    ph_ld  = 1'b0;
    ph_en  = 1'b0;
    ph_val = w_len;
    case (state)
      CLEAR:  ph_ld = 1'b1;
      LOAD_W: begin ph_en = 1'b1; ph_ld = ph_last; ph_val = f_len; end
      FEED:   begin ph_en = 1'b1; ph_ld = ph_last; end
      OUTPUT: ph_en = 1'b1;
      default: ;
    endcase
  end

  sys_array_phase_cnt #(.WIDTH(CNT_WIDTH)) u_phase (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (ph_ld),
    .en       (ph_en),
    .load_val (ph_val),
    .last     (ph_last),
    .idx      (ph_idx)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      start_d     <= 1'b0;
      w_q         <= '0;
      l_q         <= '0;
      a_q         <= '0;
      ready       <= 1'b0;
      cfg_err     <= 1'b0;
      pe_clear    <= 1'b0;
      w_load_en   <= 1'b0;
      w_row_idx   <= '0;
      a_feed_en   <= 1'b0;
      feed_step   <= '0;
      out_valid   <= 1'b0;
      out_row_idx <= '0;
      cnt         <= '0;
    end else begin
      start_d <= start_comp;
      cfg_err <= 1'b0;
      if (busy && (cnt != '1)) cnt <= cnt + 1'b1;
      case (state)
        IDLE, DONE: begin
          if (start_edge) begin
            if (cfg_ok) begin
              w_q      <= cfg_w;
              l_q      <= cfg_l;
              a_q      <= cfg_a_l;
              ready    <= 1'b0;
              cnt      <= '0;
              pe_clear <= 1'b1;
              state    <= CLEAR;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        CLEAR: begin
          pe_clear  <= 1'b0;
          w_load_en <= 1'b1;
          w_row_idx <= '0;
          state     <= LOAD_W;
        end
        LOAD_W: begin
          if (ph_last) begin
            w_load_en <= 1'b0;
            w_row_idx <= '0;
            a_feed_en <= 1'b1;
            feed_step <= '0;
            state     <= FEED;
          end else begin
            w_row_idx <= IW'(ph_idx + 1'b1);
          end
        end
        FEED: begin
          if (ph_last) begin
            a_feed_en   <= 1'b0;
            feed_step   <= '0;
            out_valid   <= 1'b1;
            out_row_idx <= '0;
            state       <= OUTPUT;
          end else begin
            feed_step <= ph_idx + 1'b1;
          end
        end
        OUTPUT: begin
          if (ph_last) begin
            out_valid   <= 1'b0;
            out_row_idx <= '0;
            ready       <= 1'b1;
            state       <= DONE;
          end else begin
            out_row_idx <= IW'(ph_idx + 1'b1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sys_array_ctrl.sv
// Directed bench for sys_array_ctrl: per-cycle strobe/index/status checks
// against hand-derived phase boundaries for several configs.
module tb_sys_array_ctrl;
  import sys_array_pkg::*;

  logic                 clk = 1'b0;
  logic                 reset_n, start_comp;
  logic [CFG_W_W-1:0]   cfg_w;
  logic [CFG_L_W-1:0]   cfg_l;
  logic [CFG_A_W-1:0]   cfg_a_l;
  logic                 busy, ready, cfg_err, pe_clear, w_load_en, a_feed_en, out_valid;
  logic [ROW_IDX_W-1:0] w_row_idx, out_row_idx;
  logic [15:0]          feed_step, cnt;
  logic [31:0]          vec;

  int pass = 0;
  int total = 0;

  always #5 clk = ~clk;

  sys_array_ctrl dut (
    .clk(clk), .reset_n(reset_n), .start_comp(start_comp),
    .cfg_w(cfg_w), .cfg_l(cfg_l), .cfg_a_l(cfg_a_l),
    .busy(busy), .ready(ready), .cfg_err(cfg_err), .pe_clear(pe_clear),
    .w_load_en(w_load_en), .w_row_idx(w_row_idx), .a_feed_en(a_feed_en),
    .feed_step(feed_step), .out_valid(out_valid), .out_row_idx(out_row_idx),
    .cnt(cnt)
  );

  // {pad, pe_clear, w_load_en, w_row_idx, a_feed_en, feed_step,
  //  out_valid, out_row_idx, ready, busy, cfg_err}
  assign vec = {3'b0, pe_clear, w_load_en, w_row_idx, a_feed_en, feed_step,
                out_valid, out_row_idx, ready, busy, cfg_err};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) pass++;
    else $error("FAIL %s: observed %h expected %h", tag, o, e);
  endtask

  // Expected outputs k cycles after the accepted start edge (k=1 is CLEAR)
  function automatic logic [31:0] exp_vec(input int k, input int w, input int l, input int a);
    int   f = a + w + l - 2;
    int   n = 3 * w + a + l;
    logic pc = 1'b0, wl = 1'b0, fe = 1'b0, ov = 1'b0, rd = 1'b0, bz;
    logic [2:0]  wi = '0, oi = '0;
    logic [15:0] fs = '0;
    if (k == 1) pc = 1'b1;
    else if (k <= w + 1) begin wl = 1'b1; wi = 3'(k - 2); end
    else if (k <= w + 1 + f) begin fe = 1'b1; fs = 16'(k - w - 2); end
    else if (k <= 2 * w + 1 + f) begin ov = 1'b1; oi = 3'(k - w - 2 - f); end
    else rd = 1'b1;
    bz = (k < n);
    return {3'b0, pc, wl, wi, fe, fs, ov, oi, rd, bz, 1'b0};
  endfunction

  // One run from a fresh start edge; pk!=0 drops start at cycle pk,
  // re-raises it at pk+1 and changes cfg_a_l mid-run.
  task automatic run(input int w, input int l, input int a, input int pk);
    int n = 3 * w + a + l;
    cfg_w = CFG_W_W'(w); cfg_l = CFG_L_W'(l); cfg_a_l = CFG_A_W'(a);
    start_comp = 1'b0;
    tick;
    start_comp = 1'b1;
    tick;
    for (int k = 1; k <= n; k++) begin
      if (pk != 0 && k == pk) begin start_comp = 1'b0; cfg_a_l = CFG_A_W'(1); end
      if (pk != 0 && k == pk + 1) start_comp = 1'b1;
      chk($sformatf("run_w%0d_l%0d_a%0d_k%0d", w, l, a, k), vec, exp_vec(k, w, l, a));
      chk($sformatf("cnt_w%0d_k%0d", w, k), 32'(cnt), 32'(k - 1));
      if (k < n) tick;
    end
  endtask

  initial begin
    reset_n = 1'b0; start_comp = 1'b0;
    cfg_w = 3'd5; cfg_l = 3'd2; cfg_a_l = 3'd5;
    tick; tick;
    chk("reset_vec", vec, 32'h0);
    chk("reset_cnt", 32'(cnt), 32'h0);
    reset_n = 1'b1;
    tick;
    chk("idle_vec", vec, 32'h0);

    // Default config, start held high through and past the run
    run(5, 2, 5, 0);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("done_hold", vec, 32'h4);
      chk("done_cnt", 32'(cnt), 32'd21);
    end

    // Rejected configs: one-cycle cfg_err, ready/cnt untouched
    start_comp = 1'b0; cfg_l = 3'd0;
    tick;
    start_comp = 1'b1;
    tick;
    chk("err_l0", vec, 32'h5);
    chk("err_l0_cnt", 32'(cnt), 32'd21);
    tick;
    chk("err_l0_end", vec, 32'h4);
    cfg_l = 3'd2; cfg_w = 3'd6; start_comp = 1'b0;
    tick;
    start_comp = 1'b1;
    tick;
    chk("err_w6", vec, 32'h5);
    tick;
    chk("err_w6_end", vec, 32'h4);

    // Minimum sizes
    run(1, 1, 1, 0);

    // Start re-pulsed during FEED and cfg_a_l changed mid-run
    run(5, 2, 5, 10);
    cfg_a_l = 3'd5;

    // Reset during LOAD_W, then a fresh run
    start_comp = 1'b0;
    tick;
    start_comp = 1'b1;
    tick;
    tick;
    chk("pre_reset_loadw", vec, exp_vec(2, 5, 2, 5));
    reset_n = 1'b0; start_comp = 1'b0;
    tick;
    chk("midrun_reset_vec", vec, 32'h0);
    chk("midrun_reset_cnt", 32'(cnt), 32'h0);
    reset_n = 1'b1;
    tick;
    chk("post_reset_idle", vec, 32'h0);
    run(5, 2, 5, 0);

    // Restart straight from DONE with identical timing
    run(5, 2, 5, 0);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
